// File: rtl/crc_check.sv
// crc_check: receive-side CRC-5 checker for 4-bit data codewords.
//
// It accepts a 9-bit codeword {data, crc} over a valid/ready handshake.
// It then shifts the codeword MSB first through a 5-bit LFSR, one bit per
// cycle, and presents the data, a pass flag and the final remainder until
// downstream takes them. Failed frames are counted by a saturating counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   codeword present on data_in/crc_in
//   in_ready   block can accept a codeword (registered, high only in IDLE)
//   data_in    received data bits
//   crc_in     received CRC bits
//   out_valid  result available (registered, high only in DONE)
//   out_ready  downstream takes the result
//   data_out   data of the checked codeword
//   crc_ok     1 when the syndrome is zero
//   syndrome   final LFSR remainder
//   err_count  saturating count of failed frames delivered
module crc_check #(
  parameter logic [4:0] POLY  = 5'b00101,
  parameter int         ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       data_in,
  input  logic [4:0]       crc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             crc_ok,
  output logic [4:0]       syndrome,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [8:0]       frame_q, frame_d;
  logic [4:0]       r_q, r_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       data_q, data_d;
  logic             ok_q, ok_d;
  logic [4:0]       syn_q, syn_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;

  // One LFSR step, fed with the frame MSB that is currently at the top of
  // the shift register.
  logic       fb;
  logic [4:0] r_step;
  assign fb     = r_q[4] ^ frame_q[8];
  assign r_step = {r_q[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ok_d    = ok_q;
    syn_d   = syn_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          frame_d = {data_in, crc_in};
          r_d     = 5'b00000;
          cnt_d   = 4'd0;
          data_d  = data_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d     = r_step;
        frame_d = {frame_q[7:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          syn_d   = r_step;
          ok_d    = (r_step == 5'b00000);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (!ok_q && (err_q != ERR_MAX)) err_d = err_q + ERR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The handshake flags are registered copies of the next state. This
    // lets in_ready fall on the accept edge itself.
    rdy_d = (state_d == IDLE);
    vld_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      syn_q   <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign data_out  = data_q;
  assign crc_ok    = ok_q;
  assign syndrome  = syn_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check. Expected syndromes come from GF(2)
// polynomial long division of the frame. Expected error counts come from a
// saturating integer tally that is updated on each result handshake.
module tb_crc_check;
  localparam logic [4:0] POLY  = 5'b00101;
  localparam int         ERR_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [3:0]       data_in = '0;
  logic [4:0]       crc_in = '0;
  logic             in_ready, out_valid, crc_ok;
  logic [3:0]       data_out;
  logic [4:0]       syndrome;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int cyc = 0;

  crc_check #(.POLY(POLY), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .crc_in(crc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .crc_ok(crc_ok), .syndrome(syndrome),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Remainder of frame(x) * x^5 divided by G(x) = x^5 + POLY.
  function automatic logic [4:0] ref_rem(input logic [8:0] frame);
    logic [13:0] v;
    logic [13:0] g;
    v = {frame, 5'b00000};
    for (int i = 13; i >= 5; i--) begin
      g = {8'b0, 1'b1, POLY};
      if (v[i]) v = v ^ (g << (i - 5));
    end
    return v[4:0];
  endfunction

  // Generator-side CRC: data(x) * x^5 mod G(x).
  function automatic logic [4:0] gen_crc(input logic [3:0] d);
    logic [8:0] v;
    logic [8:0] g;
    v = {d, 5'b00000};
    for (int i = 8; i >= 5; i--) begin
      g = {3'b0, 1'b1, POLY};
      if (v[i]) v = v ^ (g << (i - 5));
    end
    return v[4:0];
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << ERR_W) - 1) ? v : v + 1;
  endfunction

  // Offer a codeword and return #1 after the edge that accepts it.
  task automatic do_accept(input logic [3:0] d, input logic [4:0] c, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; data_in = d; crc_in = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, data_out, crc_ok, syndrome, err_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 5'h0, 8'h0})
      begin errors++; $display("FAIL reset_state got %h exp %h",
        {in_ready, out_valid, data_out, crc_ok, syndrome, err_count}, {1'b1, 20'h0}); end
    reset = 1'b0;
    err_exp = 0;
  endtask

  task automatic test_clean;
    logic [3:0] dv [2];
    logic [4:0] cv [2];
    bit ok;
    int lat;
    dv[0] = 4'b0010; cv[0] = 5'b01010;
    dv[1] = 4'b1111; cv[1] = 5'b10110;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      do_accept(dv[k], cv[k], ok);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL clean_inready_drop got %b exp 0", in_ready); end
      wait_out(lat);
      checks++;
      if (!ok || lat != 9) begin errors++; $display("FAIL clean_latency got %0d exp 9", lat); end
      checks++;
      if ({data_out, crc_ok, syndrome} !== {dv[k], 1'b1, 5'b00000})
        begin errors++; $display("FAIL clean_result got %h exp %h", {data_out, crc_ok, syndrome}, {dv[k], 1'b1, 5'b0}); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== ERR_W'(err_exp))
        begin errors++; $display("FAIL clean_handshake got v%b r%b e%0d exp v0 r1 e%0d", out_valid, in_ready, err_count, err_exp); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_corrupt;
    bit ok;
    int lat;
    out_ready = 1'b0;
    do_accept(4'b0010, 5'b01011, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 9) begin errors++; $display("FAIL corrupt_latency got %0d exp 9", lat); end
    checks++;
    if ({data_out, crc_ok, syndrome} !== {4'b0010, 1'b0, 5'b00101})
      begin errors++; $display("FAIL corrupt_result got %h exp %h", {data_out, crc_ok, syndrome}, {4'b0010, 1'b0, 5'b00101}); end
    checks++;
    if (err_count !== ERR_W'(err_exp)) begin errors++; $display("FAIL corrupt_cnt_before got %0d exp %0d", err_count, err_exp); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    err_exp = sat_inc(err_exp);
    checks++;
    if (err_count !== ERR_W'(err_exp) || out_valid !== 1'b0)
      begin errors++; $display("FAIL corrupt_cnt_after got %0d exp %0d", err_count, err_exp); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    int lat;
    logic [3:0] d1, d2;
    logic [4:0] c1, c2, s2;
    d1 = 4'($urandom); c1 = gen_crc(d1);
    d2 = ~d1;          c2 = gen_crc(d2) ^ 5'b00100;
    s2 = ref_rem({d2, c2});
    out_ready = 1'b0;
    do_accept(d1, c1, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 9) begin errors++; $display("FAIL bp_latency got %0d exp 9", lat); end
    in_valid = 1'b1; data_in = d2; crc_in = c2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, data_out, crc_ok, syndrome} !== {1'b1, 1'b0, d1, 1'b1, 5'b0})
        begin errors++; $display("FAIL bp_stall got %h exp %h",
          {out_valid, in_ready, data_out, crc_ok, syndrome}, {1'b1, 1'b0, d1, 1'b1, 5'b0}); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== ERR_W'(err_exp))
      begin errors++; $display("FAIL bp_release got v%b r%b e%0d exp v0 r1 e%0d", out_valid, in_ready, err_count, err_exp); end
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got %b exp 0", in_ready); end
    wait_out(lat);
    checks++;
    if (lat != 9 || {data_out, crc_ok, syndrome} !== {d2, 1'b0, s2})
      begin errors++; $display("FAIL bp_second got lat %0d %h exp 9 %h", lat, {data_out, crc_ok, syndrome}, {d2, 1'b0, s2}); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    err_exp = sat_inc(err_exp);
    checks++;
    if (err_count !== ERR_W'(err_exp)) begin errors++; $display("FAIL bp_cnt got %0d exp %0d", err_count, err_exp); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    int lat, t0, t1;
    logic [3:0] d1, d2;
    d1 = 4'($urandom); d2 = 4'($urandom);
    out_ready = 1'b1;
    do_accept(d1, gen_crc(d1), ok1);
    t0 = cyc;
    do_accept(d2, gen_crc(d2), ok2);
    t1 = cyc;
    checks++;
    if (!ok1 || !ok2 || (t1 - t0) != 11) begin errors++; $display("FAIL b2b_spacing got %0d exp 11", t1 - t0); end
    wait_out(lat);
    checks++;
    if (lat != 9 || {data_out, crc_ok, syndrome} !== {d2, 1'b1, 5'b0})
      begin errors++; $display("FAIL b2b_result got lat %0d %h exp 9 %h", lat, {data_out, crc_ok, syndrome}, {d2, 1'b1, 5'b0}); end
    @(posedge clk); #1;
    checks++;
    if (err_count !== ERR_W'(err_exp)) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", err_count, err_exp); end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    bit ok;
    int lat;
    logic [3:0] d, hd;
    logic [4:0] c, s;
    logic       k;
    for (int it = 0; it < 40; it++) begin
      d = 4'($urandom);
      c = ($urandom_range(0, 1) == 1) ? gen_crc(d) : 5'($urandom);
      s = ref_rem({d, c});
      k = (s == 5'b0);
      out_ready = 1'b0;
      do_accept(d, c, ok);
      wait_out(lat);
      checks++;
      if (!ok || lat != 9 || {data_out, crc_ok, syndrome} !== {d, k, s})
        begin errors++; $display("FAIL rand_result it %0d got lat %0d %h exp 9 %h", it, lat, {data_out, crc_ok, syndrome}, {d, k, s}); end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || {data_out, crc_ok, syndrome} !== {d, k, s})
          begin errors++; $display("FAIL rand_hold it %0d got %h exp %h", it, {out_valid, data_out, crc_ok, syndrome}, {1'b1, d, k, s}); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (!k) err_exp = sat_inc(err_exp);
      checks++;
      if (out_valid !== 1'b0 || err_count !== ERR_W'(err_exp))
        begin errors++; $display("FAIL rand_cnt it %0d got %0d exp %0d", it, err_count, err_exp); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    bit ok;
    int lat;
    bit seen;
    logic [3:0] d;
    d = 4'($urandom);
    out_ready = 1'b1;
    do_accept(d, gen_crc(d) ^ 5'b00001, ok);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    err_exp = 0;
    checks++;
    if ({in_ready, out_valid, data_out, crc_ok, syndrome, err_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 5'h0, 8'h0})
      begin errors++; $display("FAIL midreset_state got %h exp %h",
        {in_ready, out_valid, data_out, crc_ok, syndrome, err_count}, {1'b1, 20'h0}); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_valid got 1 exp 0"); end
    d = 4'($urandom);
    do_accept(d, gen_crc(d), ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 9 || {data_out, crc_ok, syndrome} !== {d, 1'b1, 5'b0})
      begin errors++; $display("FAIL midreset_after got lat %0d %h exp 9 %h", lat, {data_out, crc_ok, syndrome}, {d, 1'b1, 5'b0}); end
    @(posedge clk); #1;
    checks++;
    if (err_count !== ERR_W'(err_exp)) begin errors++; $display("FAIL midreset_cnt got %0d exp %0d", err_count, err_exp); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation;
    bit ok;
    int lat;
    logic [3:0] d;
    logic [4:0] c, s;
    out_ready = 1'b1;
    for (int it = 0; it < 260; it++) begin
      d = 4'($urandom);
      c = gen_crc(d) ^ 5'($urandom_range(1, 31));
      s = ref_rem({d, c});
      do_accept(d, c, ok);
      wait_out(lat);
      checks++;
      if (!ok || lat != 9 || crc_ok !== 1'b0 || syndrome !== s)
        begin errors++; $display("FAIL sat_frame it %0d got lat %0d ok %b syn %h exp 9 0 %h", it, lat, crc_ok, syndrome, s); end
      @(posedge clk); #1;
      err_exp = sat_inc(err_exp);
      checks++;
      if (err_count !== ERR_W'(err_exp))
        begin errors++; $display("FAIL sat_cnt it %0d got %0d exp %0d", it, err_count, err_exp); end
    end
    checks++;
    if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_final got %0d exp 255", err_count); end
    d = 4'($urandom);
    do_accept(d, gen_crc(d), ok);
    wait_out(lat);
    @(posedge clk); #1;
    checks++;
    if (!ok || lat != 9 || err_count !== 8'hFF)
      begin errors++; $display("FAIL sat_clean got lat %0d cnt %0d exp 9 255", lat, err_count); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side companion to the 4-bit-data / CRC-5 generator `crc`. It accepts a codeword (4 data bits plus the 5-bit CRC produced by the generator) over a valid/ready handshake. It recomputes the remainder bit-serially through a 5-bit LFSR and returns the data, a pass/fail flag and the syndrome. It also keeps a saturating count of failed frames, and sits directly downstream of the generator in the link datapath.

## Interface
- `POLY`, default 5'b00101: CRC-5 generator polynomial x^5+x^2+1, x^5 term implicit; must match the generator.
- `ERR_W`, default 8: width of the error counter.

- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: synchronous, active-high; only sampled on the rising edge of `clk`.
- `in_valid`, input, 1: codeword present on `data_in`/`crc_in`.
- `in_ready`, output, 1: block can accept a codeword.
- `data_in`, input, 4: received data bits.
- `crc_in`, input, 5: received CRC bits.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream takes the result.
- `data_out`, output, 4: data of the checked codeword.
- `crc_ok`, output, 1: 1 when the syndrome is zero.
- `syndrome`, output, 5: final LFSR remainder.
- `err_count`, output, ERR_W: number of failed frames delivered, saturating.

## Operation
- **LFSR step per bit b:**
  - fb = r[4] ^ b.
  - r <= {r[3:0],1'b0} ^ (fb ? POLY : 0).
  - Initial value 5'b00000, no final XOR.
- **Bit order:** the 9-bit frame {data_in, crc_in} is fed MSB first (data_in[3] first, crc_in[0] last). A valid codeword leaves r = 0.
- **State `IDLE`:**
  - `in_ready` = 1.
  - On in_valid & in_ready: latch the frame into a 9-bit shift register, clear r, clear the bit counter, latch `data_in` into `data_out`, go to `SHIFT`.
- **State `SHIFT`:**
  - `in_ready` = 0, `out_valid` = 0.
  - One frame bit per cycle; the counter runs 0..8.
  - After bit 8: `syndrome` <= next r, `crc_ok` <= (next r == 0), go to `DONE`.
- **State `DONE`:**
  - `out_valid` = 1; `data_out`, `crc_ok` and `syndrome` are held stable.
  - On out_valid & out_ready: go to `IDLE`. If !crc_ok and err_count != all-ones, increment `err_count`.
- **Inputs ignored outside `IDLE`:** `in_valid` is ignored in `SHIFT` and `DONE`; the source must hold it.
- **No result while `out_ready` is low:** with `out_ready` low in `DONE`, the block stalls indefinitely with no loss and no re-check.
- **Illegal state encodings** return to `IDLE`.

## Timing
- **Reset values:**
  - State `IDLE`.
  - `in_ready` = 1, `out_valid` = 0.
  - `data_out` = 0, `crc_ok` = 0, `syndrome` = 0, `err_count` = 0.
  - All are registered outputs.
- **Reset mid-frame (`SHIFT` or `DONE`):** the frame is aborted silently with no `out_valid` pulse. `err_count` clears; reset wins over any simultaneous handshake.
- **Latency:** accept at edge N, shifting at edges N+1..N+9, `out_valid` high from edge N+9.
- **Throughput:** minimum accept-to-accept spacing is 11 cycles (out_ready tied high): accept, 9 shift, DONE handshake, then IDLE accepts at the following edge.
- **Counter saturation:** at all-ones, `err_count` stays at all-ones on further failures; a passing frame never changes it.
- **`in_ready`** deasserts at the accept edge itself; a second codeword offered in the same cycle is not taken.

## Test plan
- **Clean frame 1:** reset 2 cycles, then data_in=4'b0010, crc_in=5'b01010, out_ready=1 -> out_valid 9 cycles after accept, data_out=4'b0010, crc_ok=1, syndrome=5'b00000, err_count=0.
- **Clean frame 2:** data_in=4'b1111, crc_in=5'b10110 -> crc_ok=1, syndrome=0.
- **Corrupted CRC:** data_in=4'b0010, crc_in=5'b01011 -> crc_ok=0, syndrome=5'b00101, err_count 0->1 on the handshake edge.
- **Backpressure:** hold out_ready=0 for 20 cycles in `DONE` -> outputs stable, in_ready=0, second in_valid ignored. Raise out_ready -> one handshake, then IDLE accepts the next frame.
- **Reset mid-`SHIFT`:** assert reset at shift cycle 4 -> no out_valid; in_ready=1 and all outputs 0 next cycle; a following clean frame checks normally.
- **Saturation:** 260 back-to-back failing frames with ERR_W=8 -> err_count ends at 255, not wrapping; one clean frame afterwards leaves it at 255.
